// File: rtl/vga_pkg.sv
// Shared geometry, colours and types for the SnakeWars VGA pipeline.
package vga_pkg;

  localparam int TILE_PX      = 16;
  localparam int MAP_W        = 32;
  localparam int MAP_H        = 32;
  localparam int X_OFF        = 144;
  localparam int Y_OFF        = 44;
  localparam int BLINK_FRAMES = 32;

  localparam int TILE_SH = $clog2(TILE_PX);
  localparam int ADDR_W  = $clog2(MAP_W * MAP_H);
  localparam int BLINK_W = $clog2(BLINK_FRAMES);

  // Board window bounds as 11-bit constants so compares against hcount/vcount stay width-matched.
  localparam logic [10:0] X_LO    = 11'(X_OFF);
  localparam logic [10:0] X_HI    = 11'(X_OFF + MAP_W * TILE_PX);
  localparam logic [10:0] Y_LO    = 11'(Y_OFF);
  localparam logic [10:0] Y_HI    = 11'(Y_OFF + MAP_H * TILE_PX);
  localparam logic [10:0] MAP_W_C = 11'(MAP_W);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [11:0] C_BLACK  = 12'h000;
  localparam logic [11:0] C_BG     = 12'h112;
  localparam logic [11:0] C_GRID   = 12'h222;
  localparam logic [11:0] C_WALL   = 12'h888;
  localparam logic [11:0] C_SNAKE1 = 12'h0F0;
  localparam logic [11:0] C_SNAKE2 = 12'h00F;
  localparam logic [11:0] C_FOOD   = 12'hF00;
  localparam logic [11:0] C_DEBUG  = 12'hF0F;

  typedef enum logic [2:0] {
    T_EMPTY  = 3'd0,
    T_WALL   = 3'd1,
    T_SNAKE1 = 3'd2,
    T_SNAKE2 = 3'd3,
    T_FOOD   = 3'd4
  } tile_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  typedef struct packed {
    timing_t            tim;
    logic               in_board;
    logic               blank;
    logic [TILE_SH-1:0] px;
    logic [TILE_SH-1:0] py;
  } pix_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bus: timing from vga_timing plus the rgb produced by each draw stage.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/tile_colour.sv
// Maps a tile code plus in-tile position and blink phase to a 12-bit pixel colour.
module tile_colour
  import vga_pkg::*;
(
  input  tile_t              tile,
  input  logic [TILE_SH-1:0] px,
  input  logic [TILE_SH-1:0] py,
  input  logic               phase,
  input  logic               blank,
  input  logic               in_board,
  output logic [11:0]        rgb
);

  // NOTE: rgb gets a value on every path before any branch, so no latch can be inferred.
  always_comb begin
    rgb = C_BLACK;
    if (blank) begin
      rgb = C_BLACK;
    end else if (!in_board) begin
      rgb = C_BG;
    end else if ((px == '0) || (py == '0)) begin
      rgb = C_GRID;
    end else begin
      case (tile)
        T_EMPTY:  rgb = C_BLACK;
        T_WALL:   rgb = C_WALL;
        T_SNAKE1: rgb = C_SNAKE1;
        T_SNAKE2: rgb = C_SNAKE2;
        T_FOOD:   rgb = phase ? C_BLACK : C_FOOD;
        default:  rgb = C_DEBUG;
      endcase
    end
  end

endmodule

// File: rtl/draw_board.sv
// Two-stage board renderer: stage 1 locates the tile and issues the map read, stage 2 colours it.
module draw_board
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  vga_if.slave              vga_in,
  vga_if.master             vga_out,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [2:0]        map_data,
  output logic              frame_tick
);

  // blank resets high so rgb is forced black until real pixels have filled both stages.
  localparam pix_t PIX_RST = '{tim: '0, in_board: 1'b0, blank: 1'b1, px: '0, py: '0};

  pix_t               s1_d, s1_q, s2_d, s2_q;
  logic [ADDR_W-1:0]  map_addr_d, map_addr_q;
  logic               frame_tick_d, frame_tick_q;
  logic [BLINK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic               phase_d, phase_q;
  logic [10:0]        hx, vy;
  logic               in_board;
  logic [11:0]        rgb;

  always_comb begin
    hx       = vga_in.hcount - X_LO;
    vy       = vga_in.vcount - Y_LO;
    in_board = (vga_in.hcount >= X_LO) && (vga_in.hcount < X_HI) &&
               (vga_in.vcount >= Y_LO) && (vga_in.vcount < Y_HI);

    s1_d.tim.hcount = vga_in.hcount;
    s1_d.tim.vcount = vga_in.vcount;
    s1_d.tim.hsync  = vga_in.hsync;
    s1_d.tim.vsync  = vga_in.vsync;
    s1_d.tim.hblnk  = vga_in.hblnk;
    s1_d.tim.vblnk  = vga_in.vblnk;
    s1_d.in_board   = in_board;
    s1_d.blank      = vga_in.hblnk | vga_in.vblnk;
    s1_d.px         = hx[TILE_SH-1:0];
    s1_d.py         = vy[TILE_SH-1:0];

    // Off-board pixels leave the RAM address parked on the last tile read.
    map_addr_d = map_addr_q;
    if (in_board) begin
      map_addr_d = ADDR_W'((vy >> TILE_SH) * MAP_W_C + (hx >> TILE_SH));
    end

    frame_tick_d = (vga_in.hcount == '0) && (vga_in.vcount == '0);

    s2_d = s1_q;

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_tick_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= PIX_RST;
      s2_q         <= PIX_RST;
      map_addr_q   <= '0;
      frame_tick_q <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      map_addr_q   <= map_addr_d;
      frame_tick_q <= frame_tick_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
    end
  end

  // map_data arrives in the same cycle as the stage-2 registers, so colour is decoded from them
  // directly; registering it again would add a third pipeline cycle.
  tile_colour u_tile_colour (
    .tile     (tile_t'(map_data)),
    .px       (s2_q.px),
    .py       (s2_q.py),
    .phase    (phase_q),
    .blank    (s2_q.blank),
    .in_board (s2_q.in_board),
    .rgb      (rgb)
  );

  assign vga_out.hcount = s2_q.tim.hcount;
  assign vga_out.vcount = s2_q.tim.vcount;
  assign vga_out.hsync  = s2_q.tim.hsync;
  assign vga_out.vsync  = s2_q.tim.vsync;
  assign vga_out.hblnk  = s2_q.tim.hblnk;
  assign vga_out.vblnk  = s2_q.tim.vblnk;
  assign vga_out.rgb    = rgb;
  assign map_addr       = map_addr_q;
  assign frame_tick     = frame_tick_q;

endmodule

// File: tb/tb_draw_board.sv
// Directed bench for draw_board with a synchronous board-map RAM model.
module tb_draw_board;
  import vga_pkg::*;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] map_addr;
  logic [2:0]        map_data;
  logic              frame_tick;
  logic [2:0]        ram [0:1023];
  int                n_tests = 0;
  int                n_fail  = 0;

  vga_if vga_in ();
  vga_if vga_out ();

  draw_board dut (
    .clk        (clk),
    .rst        (rst),
    .vga_in     (vga_in),
    .vga_out    (vga_out),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) map_data <= ram[map_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic vs, input logic hb, input logic vb);
    vga_in.hcount = h;
    vga_in.vcount = v;
    vga_in.hsync  = hs;
    vga_in.vsync  = vs;
    vga_in.hblnk  = hb;
    vga_in.vblnk  = vb;
  endtask

  task automatic idle();
    drive(11'd1000, 11'd610, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  function automatic logic [37:0] out_all();
    return {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
            vga_out.hblnk, vga_out.vblnk, vga_out.rgb};
  endfunction

  // One pixel in, then filler; rgb is checked exactly two clock edges later.
  task automatic pix_rgb(input string tag, input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic [11:0] exp);
    @(negedge clk) drive(h, v, 1'b0, 1'b0, hb, 1'b0);
    @(negedge clk) idle();
    @(negedge clk) check(tag, vga_out.rgb, exp);
  endtask

  task automatic addr_chk(input string tag, input logic [10:0] h, input logic [10:0] v,
                          input logic [ADDR_W-1:0] exp);
    @(negedge clk) drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) check(tag, map_addr, exp);
    idle();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) idle();
      @(negedge clk);
    end
  endtask

  logic [25:0] hist [20];

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = 3'(T_EMPTY);
    ram[0]    = 3'(T_WALL);
    ram[1]    = 3'(T_SNAKE1);
    ram[2]    = 3'(T_FOOD);
    ram[31]   = 3'(T_SNAKE2);
    ram[1023] = 3'd5;
    vga_in.rgb = 12'h000;
    idle();
    rst = 1'b1;

    // Reset: outputs held at zero during reset and on the first edge after release.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_out", out_all(), 38'h0);
    check("rst_addr", map_addr, 0);
    check("rst_tick", frame_tick, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_out", out_all(), 38'h0);
    check("rel_addr", map_addr, 0);
    check("rel_tick", frame_tick, 0);

    // Two-cycle delay of every timing field.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("delay_%0d", i),
              {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
               vga_out.hblnk, vga_out.vblnk}, hist[i-2]);
      end
      hist[i] = {11'(200 + i * 7), 11'(i), i[0], i[1], i[2], i[3]};
      drive(11'(200 + i * 7), 11'(i), i[0], i[1], i[2], i[3]);
    end
    @(negedge clk) idle();

    addr_chk("addr_1023", 11'd645, 11'd545, 10'd1023);
    addr_chk("addr_0", 11'd144, 11'd44, 10'd0);

    pix_rgb("wall", 11'd145, 11'd45, 1'b0, 12'h888);
    pix_rgb("snake1", 11'd161, 11'd45, 1'b0, 12'h0F0);
    pix_rgb("grid", 11'd160, 11'd45, 1'b0, 12'h222);
    pix_rgb("outside", 11'd100, 11'd300, 1'b0, 12'h112);
    pix_rgb("hblank", 11'd850, 11'd300, 1'b1, 12'h000);
    pix_rgb("last_col", 11'd655, 11'd45, 1'b0, 12'h00F);
    pix_rgb("past_col", 11'd656, 11'd45, 1'b0, 12'h112);
    pix_rgb("last_row", 11'd161, 11'd555, 1'b0, 12'h000);
    pix_rgb("past_row", 11'd161, 11'd556, 1'b0, 12'h112);
    pix_rgb("reserved", 11'd645, 11'd545, 1'b0, 12'hF0F);

    // frame_tick is a single-cycle pulse.
    @(negedge clk) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) check("tick_hi", frame_tick, 1);
    idle();
    @(negedge clk) check("tick_lo", frame_tick, 0);

    // Blink: that tick opened frame 1; phase flips when frame 32 starts and back at frame 64.
    pix_rgb("food_f1", 11'd181, 11'd45, 1'b0, 12'hF00);
    tick(30);
    pix_rgb("food_f31", 11'd181, 11'd45, 1'b0, 12'hF00);
    tick(1);
    pix_rgb("food_f32", 11'd181, 11'd45, 1'b0, 12'h000);
    tick(31);
    pix_rgb("food_f63", 11'd181, 11'd45, 1'b0, 12'h000);
    tick(1);
    pix_rgb("food_f64", 11'd181, 11'd45, 1'b0, 12'hF00);
    tick(32);
    pix_rgb("food_f96", 11'd181, 11'd45, 1'b0, 12'h000);

    // Mid-frame asynchronous reset on a live board pixel.
    @(negedge clk) drive(11'd161, 11'd45, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", out_all(), 38'h0);
    check("mid_rst_addr", map_addr, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) check("mid_rel1", vga_out.rgb, 12'h000);
    @(negedge clk) check("mid_rel2", vga_out.rgb, 12'h0F0);
    check("mid_rel2_h", vga_out.hcount, 11'd161);
    idle();
    pix_rgb("food_after_rst", 11'd181, 11'd45, 1'b0, 12'hF00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
